// File: rtl/game_pkg.sv
// Shared types for the game state counter.
// Control encodings, winner codes and round FSM states.
package game_pkg;

  typedef enum logic [1:0] {
    UP1    = 2'b00,
    UP_BIG = 2'b01,
    DN1    = 2'b10,
    DN_BIG = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    WHO_NONE = 2'b00,
    WHO_LOS  = 2'b01,
    WHO_WIN  = 2'b10
  } who_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_e;

endpackage

// File: rtl/game_state_gen2_if.sv
// Bus between game control / display logic and the game counter.
// master: control side; slave: counter. pause exists with GAME_PAUSE_EN.
interface game_state_gen2_if #(
  parameter int COUNTER_SIZE = 4,
  parameter int SCORE_SIZE   = 4
);
  logic [1:0]              control;
  logic [COUNTER_SIZE-1:0] i_value;
  logic                    INIT;
  logic                    gameover_ack;
`ifdef GAME_PAUSE_EN
  logic                    pause;
`endif
  logic [COUNTER_SIZE-1:0] count;
  logic                    win;
  logic                    los;
  logic [SCORE_SIZE-1:0]   win_score;
  logic [SCORE_SIZE-1:0]   los_score;
  logic [1:0]              who;
  logic                    gameover;

  modport master (
`ifdef GAME_PAUSE_EN
    output pause,
`endif
    output control, i_value, INIT,
    output gameover_ack,
    input  count, win, los,
    input  win_score, los_score,
    input  who, gameover
  );

  modport slave (
`ifdef GAME_PAUSE_EN
    input  pause,
`endif
    input  control, i_value, INIT,
    input  gameover_ack,
    output count, win, los,
    output win_score, los_score,
    output who, gameover
  );
endinterface

// File: rtl/game_state_gen2_score.sv
// Score counter: clr > inc; hit_limit flags that
// this edge's increment lands on SCORE_LIMIT.
module game_score_counter #(
  parameter int SCORE_SIZE  = 4,
  parameter int SCORE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [SCORE_SIZE-1:0] score,
  output logic                  hit_limit
);

  logic [SCORE_SIZE-1:0] score_inc;

  assign score_inc = score + SCORE_SIZE'(1);
  assign hit_limit = inc &&
    (score_inc == SCORE_SIZE'(SCORE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset)    score <= '0;
    else if (clr) score <= '0;
    else if (inc) score <= score_inc;
  end

endmodule

// File: rtl/game_state_gen2.sv
// Game counter: multi-mode main counter, win/lose scores, round FSM.
// Ports: clk, reset, bus (slave). Optional pause via GAME_PAUSE_EN.
module game_state_gen2
  import game_pkg::*;
#(
  parameter int COUNTER_SIZE = 4,
  parameter int SCORE_SIZE   = 4,
  parameter int SCORE_LIMIT  = 15,
  parameter int STEP_BIG     = 2
) (
  input logic        clk,
  input logic        reset,
  game_state_gen2_if.slave bus
);

  localparam int CS = COUNTER_SIZE;

  state_e          state, state_nxt;
  logic [CS-1:0]   count_q;
  logic [CS-1:0]   delta;
  logic [1:0]      who_q;
  logic            pause_w;
  logic            run_en;
  logic            win_w, los_w, go_w;
  logic            win_hit, los_hit;
  logic [SCORE_SIZE-1:0] ws, ls;

`ifdef GAME_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  assign run_en = (state == RUN) && !pause_w;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.INIT) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN:  if (win_hit || los_hit)
                state_nxt = OVER;
        OVER: if (bus.gameover_ack)
                state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    win_w = 1'b0;
    los_w = 1'b0;
    go_w  = 1'b0;
    unique case (state)
      RUN: begin
        win_w = run_en && (count_q == '1);
        los_w = run_en && (count_q == '0);
      end
      OVER:    go_w = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    delta = CS'(1);
    unique case (ctrl_e'(bus.control))
      UP_BIG, DN_BIG: delta = CS'(STEP_BIG);
      default:        delta = CS'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if (bus.INIT)
      count_q <= bus.i_value;
    else if (run_en)
      count_q <= bus.control[1] ?
        count_q - delta : count_q + delta;
  end

  always_ff @(posedge clk) begin
    if (reset)
      who_q <= WHO_NONE;
    else if (bus.INIT)
      who_q <= WHO_NONE;
    else if (state == OVER && bus.gameover_ack)
      who_q <= WHO_NONE;
    else if (win_hit)
      who_q <= WHO_WIN;
    else if (los_hit)
      who_q <= WHO_LOS;
  end

  game_score_counter #(
    .SCORE_SIZE  (SCORE_SIZE),
    .SCORE_LIMIT (SCORE_LIMIT)
  ) u_win (
    .clk       (clk),
    .reset     (reset),
    .clr       (bus.INIT),
    .inc       (win_w),
    .score     (ws),
    .hit_limit (win_hit)
  );

  game_score_counter #(
    .SCORE_SIZE  (SCORE_SIZE),
    .SCORE_LIMIT (SCORE_LIMIT)
  ) u_los (
    .clk       (clk),
    .reset     (reset),
    .clr       (bus.INIT),
    .inc       (los_w),
    .score     (ls),
    .hit_limit (los_hit)
  );

  assign bus.count     = count_q;
  assign bus.win       = win_w;
  assign bus.los       = los_w;
  assign bus.win_score = ws;
  assign bus.los_score = ls;
  assign bus.who       = who_q;
  assign bus.gameover  = go_w;

endmodule
